// File: rtl/seq_restoring_div.sv
// Sequential 4-bit unsigned restoring divider. One trial subtraction per
// clock through a shared parallel_sub instance, under a start/busy/done
// handshake. A zero divisor finishes immediately with divZero set.
//
// Handshake: start is sampled on a rising edge only when busy=0 (IDLE or
// DONE). The operands are captured on that same edge. done is high for
// exactly the one cycle that follows the final iteration. quotient,
// remainder and divZero then hold until the next accepted start. A start
// seen while busy=1 is dropped and is not queued.

// 4-bit ripple-borrow subtractor: diff = a - b - borrowIn.
module parallel_sub (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       borrowIn,
  output logic [3:0] diff,
  output logic       borrowOut
);
  logic [4:0] br;

  assign br[0] = borrowIn;

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_bit
      assign diff[i]  = a[i] ^ b[i] ^ br[i];
      assign br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
    end
  endgenerate

  assign borrowOut = br[4];
endmodule

module seq_restoring_div (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       divZero
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] rem_q, rem_d;
  logic [3:0] dvd_q, dvd_d;
  logic [3:0] dvs_q, dvs_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] quo_q, quo_d;
  logic [3:0] rmd_q, rmd_d;
  logic       dz_q, dz_d;

  logic [4:0] trial;
  logic [3:0] sub_diff;
  logic       sub_borrow;
  logic       trial_neg;

  // Trial operand is the partial remainder with the next dividend bit appended.
  assign trial = {rem_q, dvd_q[3]};

  parallel_sub u_sub (
    .a         (trial[3:0]),
    .b         (dvs_q),
    .borrowIn  (1'b0),
    .diff      (sub_diff),
    .borrowOut (sub_borrow)
  );

  // The 5-bit difference is negative only when bit 4 of the trial is 0 and the low nibble borrowed.
  assign trial_neg = ~trial[4] & sub_borrow;

  // Next-state and datapath update. Results are written only on the way into DONE.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dz_d    = dz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          rem_d = 4'd0;
          dvd_d = dividend;
          dvs_d = divisor;
          cnt_d = 2'd0;
          dz_d  = 1'b0;
          if (divisor == 4'd0) begin
            state_d = S_DONE;
            quo_d   = 4'hF;
            rmd_d   = dividend;
            dz_d    = 1'b1;
          end else begin
            state_d = S_BUSY;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_BUSY: begin
        rem_d = trial_neg ? trial[3:0] : sub_diff;
        dvd_d = {dvd_q[2:0], ~trial_neg};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = S_DONE;
          quo_d   = dvd_d;
          rmd_d   = rem_d;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers. Reset aborts any division in flight.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_IDLE;
      rem_q   <= 4'd0;
      dvd_q   <= 4'd0;
      dvs_q   <= 4'd0;
      cnt_q   <= 2'd0;
      quo_q   <= 4'd0;
      rmd_q   <= 4'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dz_q    <= dz_d;
    end
  end

  assign busy      = (state_q == S_BUSY);
  assign done      = (state_q == S_DONE);
  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign divZero   = dz_q;
endmodule

// File: tb/tb_seq_restoring_div.sv
// Bench for seq_restoring_div: directed handshake cases plus random operands,
// checked against an arithmetic divide/modulo reference.
module tb_seq_restoring_div;
  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       start = 1'b0;
  logic [3:0] dividend = 4'd0;
  logic [3:0] divisor = 4'd0;
  logic       busy, done, divZero;
  logic [3:0] quotient, remainder;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected {divZero, quotient, remainder}, one entry per issued division.
  logic [8:0] exp_q[$];

  seq_restoring_div dut (
    .clk       (clk),
    .resetN    (resetN),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .divZero   (divZero)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: plain unsigned divide, with the zero-divisor convention.
  function automatic logic [8:0] model(input logic [3:0] a, input logic [3:0] b);
    if (b == 4'd0) return {1'b1, 4'hF, a};
    return {1'b0, 4'(a / b), 4'(a % b)};
  endfunction

  // Pulse start for one accepting edge. Returns at the negedge after that edge.
  task automatic start_op(input logic [3:0] a, input logic [3:0] b);
    exp_q.push_back(model(a, b));
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done. edges counts rising edges from start assertion.
  task automatic wait_done(output int edges, output int busy_cyc);
    edges = 1; busy_cyc = 0;
    while (!done && edges < 20) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      edges++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic check_result(input string tag);
    logic [8:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_quotient"}, 32'(quotient), 32'(e[7:4]));
    check({tag, "_remainder"}, 32'(remainder), 32'(e[3:0]));
    check({tag, "_divzero"}, 32'(divZero), 32'(e[8]));
  endtask

  // Full single division: latency, busy length, result, done pulse width.
  task automatic run_div(input string tag, input logic [3:0] a, input logic [3:0] b);
    int edges, bc;
    start_op(a, b);
    wait_done(edges, bc);
    check({tag, "_latency"}, 32'(edges), (b == 4'd0) ? 32'd1 : 32'd5);
    check({tag, "_busy_cycles"}, 32'(bc), (b == 4'd0) ? 32'd0 : 32'd4);
    check_result(tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int edges, bc, done_seen;

    // Reset state.
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_divzero", 32'(divZero), 32'd0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;

    // Directed cases.
    run_div("d13_3", 4'd13, 4'd3);
    run_div("d15_1", 4'd15, 4'd1);
    run_div("d0_5", 4'd0, 4'd5);
    run_div("d5_7", 4'd5, 4'd7);
    run_div("d15_15", 4'd15, 4'd15);
    run_div("d9_0", 4'd9, 4'd0);
    run_div("d8_2", 4'd8, 4'd2);

    // Start during BUSY is ignored.
    start_op(4'd14, 4'd4);
    @(negedge clk);
    start = 1'b1; dividend = 4'd3; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(edges, bc);
    check_result("ignore");

    // Start held high in the DONE cycle is accepted there.
    start_op(4'd7, 4'd2);
    wait_done(edges, bc);
    check_result("held_a");
    start = 1'b1; dividend = 4'd9; divisor = 4'd4;
    exp_q.push_back(model(4'd9, 4'd4));
    @(negedge clk);
    start = 1'b0;
    check("held_accept_busy", 32'(busy), 32'd1);
    check("held_accept_done", 32'(done), 32'd0);
    wait_done(edges, bc);
    check("held_latency", 32'(edges), 32'd5);
    check_result("held_b");
    @(negedge clk);

    // Asynchronous reset mid-division.
    start_op(4'd11, 4'd2);
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_quotient", 32'(quotient), 32'd0);
    check("arst_remainder", 32'(remainder), 32'd0);
    check("arst_divzero", 32'(divZero), 32'd0);
    void'(exp_q.pop_front());
    @(negedge clk);
    resetN = 1'b1;
    done_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("arst_no_done", 32'(done_seen), 32'd0);
    run_div("d11_2", 4'd11, 4'd2);

    // Random operands.
    for (int k = 0; k < 40; k++) begin
      run_div("rnd", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
